// File: rtl/fir_sym_cmac_engine.sv
// Time-multiplexed complex MAC engine for a symmetric FIR: folds NTAPS samples into
// pre-added pairs, multiplies on NLANES pipelined lanes over PHASES cycles, then reduces.
module fir_sym_cmac_engine #(
  parameter int NTAPS  = 29,
  parameter int NLANES = 5,
  parameter int SAMP_W = 24,
  parameter int COEF_W = 24,
  parameter int ACC_W  = 54
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_clear,
  input  logic                                 i_in_valid,
  output logic                                 o_in_ready,
  input  logic                                 i_cplx_mode,
  input  logic [NTAPS*SAMP_W-1:0]              i_samp_i,
  input  logic [NTAPS*SAMP_W-1:0]              i_samp_q,
  input  logic [((NTAPS+1)/2)*COEF_W-1:0]      i_coef_i,
  input  logic [((NTAPS+1)/2)*COEF_W-1:0]      i_coef_q,
  output logic                                 o_out_valid,
  input  logic                                 i_out_ready,
  output logic signed [ACC_W-1:0]              o_out_i,
  output logic signed [ACC_W-1:0]              o_out_q
);

  localparam int NFOLD  = (NTAPS + 1) / 2;
  localparam int PHASES = (NFOLD + NLANES - 1) / NLANES;
  localparam int PH_W   = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int MW     = SAMP_W + COEF_W + 2;
  localparam int MIN_ACC = MW + $clog2(NFOLD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

  if (ACC_W < MIN_ACC) begin : g_acc_chk
    $error("fir_sym_cmac_engine: ACC_W=%0d below required %0d", ACC_W, MIN_ACC);
  end
  if ((NTAPS < 3) || (NTAPS % 2 == 0)) begin : g_taps_chk
    $error("fir_sym_cmac_engine: NTAPS=%0d must be odd and >= 3", NTAPS);
  end
  if ((NLANES < 1) || (NLANES > NFOLD)) begin : g_lanes_chk
    $error("fir_sym_cmac_engine: NLANES=%0d must be in 1..%0d", NLANES, NFOLD);
  end

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_REDUCE, S_DONE} state_t;

  state_t r_state, w_next;
  logic [PH_W-1:0] r_phase;
  logic r_drain, r_v1, r_v2;
  logic w_accept;

  logic [NTAPS*SAMP_W-1:0] r_samp_i, r_samp_q;
  logic [NFOLD*COEF_W-1:0] r_coef_i, r_coef_q;

  logic signed [SAMP_W:0]   w_pre_i [NLANES];
  logic signed [SAMP_W:0]   w_pre_q [NLANES];
  logic signed [COEF_W-1:0] w_c_i   [NLANES];
  logic signed [COEF_W-1:0] w_c_q   [NLANES];
  logic signed [SAMP_W:0]   r_pre_i [NLANES];
  logic signed [SAMP_W:0]   r_pre_q [NLANES];
  logic signed [COEF_W-1:0] r_c_i   [NLANES];
  logic signed [COEF_W-1:0] r_c_q   [NLANES];
  logic signed [MW-1:0]     r_mul_i [NLANES];
  logic signed [MW-1:0]     r_mul_q [NLANES];
  logic signed [ACC_W-1:0]  r_acc_i [NLANES];
  logic signed [ACC_W-1:0]  r_acc_q [NLANES];
  logic signed [ACC_W-1:0]  w_sum_i, w_sum_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (i_in_valid) w_next = S_RUN;
        S_RUN:    if (r_phase == PH_LAST) w_next = S_DRAIN;
        S_DRAIN:  if (r_drain) w_next = S_REDUCE;
        S_REDUCE: w_next = S_DONE;
        S_DONE:   if (i_out_ready) w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_in_ready  = i_rst_n && (r_state == S_IDLE) && !i_clear;
    o_out_valid = (r_state == S_DONE);
    w_accept    = i_in_valid && o_in_ready;
  end

  // r_v1/r_v2 track which pipeline stages hold a live phase so only those reach the accumulators
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
      r_drain <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
    end else if (i_clear) begin
      r_phase <= '0;
      r_drain <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
    end else begin
      r_v1    <= (r_state == S_RUN);
      r_v2    <= r_v1;
      r_phase <= ((r_state == S_RUN) && (r_phase != PH_LAST)) ? r_phase + PH_W'(1) : '0;
      r_drain <= (r_state == S_DRAIN) && !r_drain;
    end
  end

  // Real mode is folded into a zero Q coefficient so the datapath is always complex
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_samp_i <= '0;
      r_samp_q <= '0;
      r_coef_i <= '0;
      r_coef_q <= '0;
    end else if (w_accept) begin
      r_samp_i <= i_samp_i;
      r_samp_q <= i_samp_q;
      r_coef_i <= i_coef_i;
      r_coef_q <= i_cplx_mode ? i_coef_q : '0;
    end
  end

  always_comb begin
    int k;
    int m;
    k = 0;
    m = 0;
    for (int l = 0; l < NLANES; l++) begin
      w_pre_i[l] = '0;
      w_pre_q[l] = '0;
      w_c_i[l]   = '0;
      w_c_q[l]   = '0;
      k = l * PHASES + int'(r_phase);
      m = NTAPS - 1 - k;
      if (k < NFOLD) begin
        w_c_i[l]   = r_coef_i[k*COEF_W +: COEF_W];
        w_c_q[l]   = r_coef_q[k*COEF_W +: COEF_W];
        w_pre_i[l] = (SAMP_W+1)'($signed(r_samp_i[k*SAMP_W +: SAMP_W]));
        w_pre_q[l] = (SAMP_W+1)'($signed(r_samp_q[k*SAMP_W +: SAMP_W]));
        if (k != NFOLD - 1) begin
          w_pre_i[l] = w_pre_i[l] + (SAMP_W+1)'($signed(r_samp_i[m*SAMP_W +: SAMP_W]));
          w_pre_q[l] = w_pre_q[l] + (SAMP_W+1)'($signed(r_samp_q[m*SAMP_W +: SAMP_W]));
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre_i <= '{default: '0};
      r_pre_q <= '{default: '0};
      r_c_i   <= '{default: '0};
      r_c_q   <= '{default: '0};
      r_mul_i <= '{default: '0};
      r_mul_q <= '{default: '0};
    end else begin
      r_pre_i <= w_pre_i;
      r_pre_q <= w_pre_q;
      r_c_i   <= w_c_i;
      r_c_q   <= w_c_q;
      for (int l = 0; l < NLANES; l++) begin
        r_mul_i[l] <= MW'(r_pre_i[l]) * MW'(r_c_i[l]) - MW'(r_pre_q[l]) * MW'(r_c_q[l]);
        r_mul_q[l] <= MW'(r_pre_i[l]) * MW'(r_c_q[l]) + MW'(r_pre_q[l]) * MW'(r_c_i[l]);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc_i <= '{default: '0};
      r_acc_q <= '{default: '0};
    end else if (i_clear || w_accept) begin
      r_acc_i <= '{default: '0};
      r_acc_q <= '{default: '0};
    end else if (r_v2) begin
      for (int l = 0; l < NLANES; l++) begin
        r_acc_i[l] <= r_acc_i[l] + ACC_W'(r_mul_i[l]);
        r_acc_q[l] <= r_acc_q[l] + ACC_W'(r_mul_q[l]);
      end
    end
  end

  always_comb begin
    w_sum_i = '0;
    w_sum_q = '0;
    for (int l = 0; l < NLANES; l++) begin
      w_sum_i = w_sum_i + r_acc_i[l];
      w_sum_q = w_sum_q + r_acc_q[l];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_i <= '0;
      o_out_q <= '0;
    end else if ((r_state == S_REDUCE) && !i_clear) begin
      o_out_i <= w_sum_i;
      o_out_q <= w_sum_q;
    end
  end

endmodule
